// File: rtl/tetris_input_pkg.sv
// rtl/tetris_input_pkg.sv - shared constants and types for the joystick input path
package tetris_input_pkg;

    localparam int NUM_BTN = 8;

    // Bit positions of the JB header pins inside the buttons vector
    localparam int BTN_UP    = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_SL    = 4;
    localparam int BTN_SR    = 5;
    localparam int BTN_HOLD  = 6;
    localparam int BTN_RST   = 7;

    // Event code per button, nibble i holds the JB pin number of bit i
    localparam logic [31:0] KEY_CODE_LUT = {4'd10, 4'd9, 4'd8, 4'd7, 4'd4, 4'd3, 4'd2, 4'd1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    function automatic logic [3:0] code_of(input logic [2:0] idx);
        return KEY_CODE_LUT[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchronizer plus stable-count debouncer for one pin
module button_debounce
    import tetris_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          rise_q,  rise_d;
    logic          fall_q,  fall_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Count consecutive mismatch cycles; any agreement restarts the count
    always_comb begin
        sync1_d = pin;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; rise/fall are one-cycle pulses aligned with the level change
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/joystick_input_controller.sv
// rtl/joystick_input_controller.sv - debounced key events with auto-repeat, queued for the CPU
module joystick_input_controller
    import tetris_input_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 50000,
    parameter int         DAS_CYCLES      = 8000000,
    parameter int         ARR_CYCLES      = 2500000,
    parameter logic [7:0] REPEAT_MASK     = 8'b0000_1110,
    parameter int         DEPTH           = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] buttons,
    input  logic       key_ack,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [7:0] level,
    output logic       overflow
);

    localparam int TMAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int TW   = $clog2(TMAX + 1) + 1;
    localparam int AW   = $clog2(DEPTH);

    logic [7:0] lvl;
    logic [7:0] rise;
    logic [7:0] fall;

    // One synchronizer/debouncer per pin
    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clock(clock),
                .reset(reset),
                .pin  (buttons[g]),
                .level(lvl[g]),
                .rise (rise[g]),
                .fall (fall[g])
            );
        end
    endgenerate

    rpt_state_e    state_q,  state_d;
    logic [2:0]    target_q, target_d;
    logic [TW-1:0] timer_q,  timer_d;
    logic          fire;
    logic [7:0]    fire_vec;
    logic [7:0]    rpt_rise;

    // Auto-repeat: newest repeatable press retargets, target release returns to IDLE
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        timer_d  = timer_q;
        fire     = 1'b0;
        fire_vec = '0;
        rpt_rise = rise & REPEAT_MASK;
        case (state_q)
            DELAY: begin
                if (timer_q == TW'(DAS_CYCLES)) begin
                    fire    = 1'b1;
                    state_d = REPEAT;
                    timer_d = TW'(1);
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REPEAT: begin
                if (timer_q == TW'(ARR_CYCLES)) begin
                    fire    = 1'b1;
                    timer_d = TW'(1);
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (state_q != IDLE && fall[target_q]) begin
            fire    = 1'b0;
            state_d = IDLE;
            timer_d = '0;
        end
        if (|rpt_rise) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (rpt_rise[i]) begin
                    target_d = 3'(i);
                end
            end
            state_d = DELAY;
            timer_d = TW'(1);
        end
        if (fire) begin
            fire_vec[target_q] = 1'b1;
        end
    end

    // Repeat FSM registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            timer_q  <= timer_d;
        end
    end

    logic [7:0] pending_q, pending_d;
    logic [7:0] req;
    logic [2:0] win_idx;
    logic       push;
    logic [3:0] push_code;

    // Highest pin number wins the single push slot; losers stay pending
    always_comb begin
        req     = pending_q | rise | fire_vec;
        win_idx = '0;
        push    = 1'b0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (req[i]) begin
                win_idx = 3'(i);
                push    = 1'b1;
            end
        end
        pending_d = req;
        if (push) begin
            pending_d[win_idx] = 1'b0;
        end
        push_code = code_of(win_idx);
    end

    logic [3:0]  mem_q [DEPTH];
    logic [3:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q,  key_code_d;
    logic          overflow_q,  overflow_d;
    logic          pop;
    logic          wr_en;

    // Event FIFO; a full push is dropped unless a pop frees the slot in the same cycle
    always_comb begin
        mem_d       = mem_q;
        pop         = key_ack && (count_q != '0);
        wr_en       = push && ((count_q != (AW+1)'(DEPTH)) || pop);
        overflow_d  = overflow_q | (push && !wr_en);
        if (wr_en) begin
            mem_d[wr_ptr_q] = push_code;
        end
        wr_ptr_d    = wr_ptr_q + AW'(wr_en);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        key_valid_d = (count_d != '0);
        key_code_d  = key_valid_d ? mem_d[rd_ptr_d] : 4'd0;
    end

    // FIFO, pending and registered output state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            overflow_q  <= overflow_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign level     = lvl;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_joystick_input_controller.sv
// tb/tb_joystick_input_controller.sv - directed self-checking bench for joystick_input_controller
module tb_joystick_input_controller;

    logic       clock;
    logic       reset;
    logic [7:0] buttons;
    logic       key_ack;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] level;
    logic       overflow;

    int n_vec  = 0;
    int n_miss = 0;

    joystick_input_controller #(
        .DEBOUNCE_CYCLES(4),
        .DAS_CYCLES     (20),
        .ARR_CYCLES     (8),
        .REPEAT_MASK    (8'b0000_1110),
        .DEPTH          (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .buttons  (buttons),
        .key_ack  (key_ack),
        .key_valid(key_valid),
        .key_code (key_code),
        .level    (level),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pop_one();
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
    endtask

    int         exp_edge [6] = '{6, 26, 34, 42, 50, 58};
    int         ov_idx   [5] = '{0, 4, 5, 6, 7};
    logic [3:0] tail_exp [4] = '{4'd8, 4'd9, 4'd4, 4'd0};
    int         ev_edge [$];
    logic [3:0] ev_code [$];
    logic       ack_next;
    logic       bounce_hi;

    initial begin
        reset   = 1'b0;
        buttons = '0;
        key_ack = 1'b0;
        tick(3);
        expect_eq("rst_valid", key_valid, 0);
        expect_eq("rst_code", key_code, 0);
        expect_eq("rst_level", level, 0);
        expect_eq("rst_overflow", overflow, 0);
        reset = 1'b1;
        tick(2);

        // Clean press of left
        buttons[3] = 1'b1;
        tick(5);
        expect_eq("press_level_e4", level, 8'h00);
        tick(1);
        expect_eq("press_level_e5", level, 8'h08);
        expect_eq("press_valid_e5", key_valid, 0);
        tick(1);
        expect_eq("press_valid_e6", key_valid, 1);
        expect_eq("press_code_e6", key_code, 4);
        pop_one();
        expect_eq("press_pop_valid", key_valid, 0);
        expect_eq("press_pop_code", key_code, 0);
        buttons[3] = 1'b0;
        tick(30);
        expect_eq("press_quiet", key_valid, 0);
        expect_eq("press_release_level", level, 8'h00);

        // Bounce on up never settles
        bounce_hi = 1'b0;
        for (int c = 0; c < 30; c++) begin
            buttons[0] = (c < 20) && ((c / 2) % 2 == 0);
            tick(1);
            if (level[0] || key_valid) bounce_hi = 1'b1;
        end
        expect_eq("bounce_level", bounce_hi, 0);
        expect_eq("bounce_valid", key_valid, 0);

        // Auto-repeat on right with immediate acks
        ack_next = 1'b0;
        for (int e = 0; e < 100; e++) begin
            buttons[1] = (e < 60);
            key_ack    = ack_next;
            @(posedge clock);
            #1;
            ack_next = 1'b0;
            if (key_valid) begin
                ev_edge.push_back(e);
                ev_code.push_back(key_code);
                ack_next = 1'b1;
            end
        end
        key_ack = 1'b0;
        expect_eq("rpt_count", ev_edge.size(), 6);
        for (int i = 0; i < 6 && i < ev_edge.size(); i++) begin
            expect_eq($sformatf("rpt_edge%0d", i), ev_edge[i], exp_edge[i]);
            expect_eq($sformatf("rpt_code%0d", i), ev_code[i], 2);
        end

        // Simultaneous reset-button and up
        buttons = 8'h81;
        tick(7);
        expect_eq("simul_level", level, 8'h81);
        expect_eq("simul_first", key_code, 10);
        tick(1);
        expect_eq("simul_head_held", key_code, 10);
        pop_one();
        expect_eq("simul_second", key_code, 1);
        pop_one();
        expect_eq("simul_empty", key_valid, 0);
        buttons = '0;
        tick(12);

        // Overflow: five distinct non-repeating presses, no acks
        for (int i = 0; i < 5; i++) begin
            buttons[ov_idx[i]] = 1'b1;
            tick(8);
            if (i == 3) expect_eq("ovf_before", overflow, 0);
        end
        expect_eq("ovf_set", overflow, 1);
        expect_eq("ovf_head", key_code, 1);
        buttons[3] = 1'b1;
        tick(6);
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
        buttons[3] = 1'b0;
        expect_eq("ovf_pushpop_head", key_code, 7);
        expect_eq("ovf_pushpop_valid", key_valid, 1);
        for (int i = 0; i < 4; i++) begin
            pop_one();
            expect_eq($sformatf("ovf_drain%0d", i), key_code, tail_exp[i]);
        end
        expect_eq("ovf_drained", key_valid, 0);
        expect_eq("ovf_sticky", overflow, 1);
        buttons = '0;
        tick(12);

        // Reset with three queued events and up held
        buttons[4] = 1'b1;
        tick(8);
        buttons[5] = 1'b1;
        tick(8);
        buttons[4] = 1'b0;
        buttons[5] = 1'b0;
        buttons[0] = 1'b1;
        tick(8);
        expect_eq("pre_rst_head", key_code, 7);
        expect_eq("pre_rst_level", level, 8'h01);
        reset = 1'b0;
        #1;
        expect_eq("mid_rst_valid", key_valid, 0);
        expect_eq("mid_rst_code", key_code, 0);
        expect_eq("mid_rst_level", level, 0);
        expect_eq("mid_rst_overflow", overflow, 0);
        tick(2);
        reset = 1'b1;
        tick(5);
        expect_eq("post_rst_level_e4", level, 8'h00);
        tick(1);
        expect_eq("post_rst_level_e5", level, 8'h01);
        expect_eq("post_rst_valid_e5", key_valid, 0);
        tick(1);
        expect_eq("post_rst_valid_e6", key_valid, 1);
        expect_eq("post_rst_code_e6", key_code, 1);
        pop_one();
        tick(20);
        expect_eq("post_rst_single", key_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/joystick_input_controller.md
# joystick_input_controller

Conditions the eight raw joystick/button pins (JB header) into clean, debounced key events for the Tetris CPU. Sits directly upstream of the processor's memory-mapped input register 27. It synchronizes and debounces each pin, generates press events and auto-repeat for movement keys, and queues the events in a small FIFO. The CPU pops one event per read of register 27, so a single press is never seen twice and is never lost between polls.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a level change (1 ms at 50 MHz).
- DAS_CYCLES, 8000000: hold time before auto-repeat starts (160 ms).
- ARR_CYCLES, 2500000: auto-repeat period (50 ms).
- REPEAT_MASK, 8'b0000_1110: buttons that auto-repeat (right, down, left).
- DEPTH, 4: event FIFO entries (power of two, ≥2).

Ports:
- clock  in  1  system clock (50 MHz CPU clock).
- reset  in  1  asynchronous, active-low reset.
- buttons  in  8  raw pins: [0]=JB1 up, [1]=JB2 right, [2]=JB3 down, [3]=JB4 left, [4]=JB7 SL, [5]=JB8 SR, [6]=JB9 hold, [7]=JB10 reset-button; active-high.
- key_ack  in  1  one-cycle pop strobe, driven by the wrapper when the CPU reads r27.
- key_valid  out  1  FIFO non-empty.
- key_code  out  4  head event code: 1,2,3,4,7,8,9,10 (JB pin number); 0 when empty.
- level  out  8  debounced button levels (drives LED[7:0]).
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
- Sync: two-flop synchronizer per bit. Both flops reset to 0.
- Debounce: one counter per bit.
  - While sync output ≠ level, the counter increments; otherwise it clears.
  - On reaching DEBOUNCE_CYCLES, level flips and the counter clears.
  - Any mismatch gap restarts the count.
- Press detect: a 0→1 transition of level[i] sets pending[i]. Release generates no event.
- Auto-repeat FSM: IDLE → DELAY → REPEAT.
  - The rising level of a REPEAT_MASK button latches it as the repeat target, loads the timer and enters DELAY. A newer repeatable press retargets and reloads.
  - DELAY: the timer counts to DAS_CYCLES, then sets pending[target] and enters REPEAT.
  - REPEAT: pending[target] is set every ARR_CYCLES.
  - A falling level of the target returns the FSM to IDLE from any state.
- Push arbitration: at most one push per cycle. The highest-priority pending bit wins, in the order 10, 9, 8, 7, 4, 3, 2, 1. Its pending bit clears on push; the other bits wait.
- Codes: bit i maps to {1,2,3,4,7,8,9,10}[i].
- FIFO:
  - key_ack with the FIFO empty is ignored.
  - Push while full with no pop in the same cycle: the event is dropped, its pending bit still clears, and overflow sets.
  - Push and pop in the same cycle when full: both occur, and the count is unchanged.
  - Pointers wrap modulo DEPTH.
- overflow clears only on reset.

## Timing
- Reset (asynchronous assert, synchronous release) clears everything:
  - Outputs: key_valid=0, key_code=0, level=0, overflow=0.
  - Internal: FIFO empty, pending=0, FSM in IDLE, all counters 0.
- Reset mid-debounce discards partial counts. A button held through reset release produces one press event after the full debounce.
- Input latency, with edge 0 as the first clock edge that samples the new pin value:
  - level changes after edge DEBOUNCE_CYCLES+1.
  - key_valid and key_code are valid after edge DEBOUNCE_CYCLES+2.
- key_code and key_valid are registered.
- Pop latency: after the edge that samples key_ack, key_code shows the next entry, or 0 when empty.
- First repeat event is pushed DAS_CYCLES+1 cycles after the level rise. Later repeats are exactly ARR_CYCLES apart, plus any arbitration delay.

## Structure
- Package tetris_input_pkg holds:
  - button index constants (BTN_UP … BTN_RST);
  - the code lookup constant;
  - the repeat FSM state enum (IDLE, DELAY, REPEAT).
- Sub-module button_debounce (sync + counter + level), instantiated 8× through a generate loop.
- The FSM, arbiter and FIFO live in the top module.

## Test plan
Test parameters: DEBOUNCE_CYCLES=4, DAS_CYCLES=20, ARR_CYCLES=8, DEPTH=4.
- Clean press: hold buttons[3] high → level[3]=1 after edge 5; key_valid=1 and key_code=4 after edge 6; key_ack → key_valid=0, key_code=0.
- Bounce: toggle buttons[0] every 2 cycles for 20 cycles, then hold low → level[0] stays 0 and no event is pushed.
- Auto-repeat: hold buttons[1] for 60 cycles, acking each event → code-2 events at the press, at +21, and every 8 cycles after; none after release.
- Simultaneous: buttons[7] and buttons[0] rise in the same cycle → FIFO holds 10, then 1, on consecutive cycles.
- Overflow: 5 distinct presses with no ack → 4 entries retained in order, 5th dropped, overflow=1; push+pop in the same cycle while full → count stays 4.
- Reset mid-operation: assert reset with 3 queued events and a held button → all outputs 0 immediately; after release, one press event after debounce.
